// File: rtl/store_commit_buffer_pkg.sv
// Shared definitions for the store commit buffer: widths, access-size codes
// and the layout of one buffered store.
package store_commit_buffer_pkg;

    localparam int unsigned SIZE_DCACHE_ADDR = 32;
    localparam int unsigned SIZE_DATA        = 32;
    localparam int unsigned LDST_TYPES_LOG   = 2;

    localparam logic [LDST_TYPES_LOG-1:0] LDST_BYTE      = 2'b00;
    localparam logic [LDST_TYPES_LOG-1:0] LDST_HALF_WORD = 2'b01;
    localparam logic [LDST_TYPES_LOG-1:0] LDST_WORD      = 2'b10;

    typedef struct packed {
        logic                        valid;
        logic [SIZE_DCACHE_ADDR-1:0] addr;
        logic [SIZE_DATA-1:0]        data;
        logic [LDST_TYPES_LOG-1:0]   size;
    } store_entry_t;

endpackage

// File: rtl/store_commit_buffer_addr_match.sv
// Parallel word-address compare of a load probe against every valid buffered
// store, reduced to a single conflict bit.
import store_commit_buffer_pkg::*;

module scb_addr_match #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = SIZE_DCACHE_ADDR
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [ADDR_W-1:0] addr [DEPTH],
    input  logic              probe_en,
    input  logic [ADDR_W-1:0] probe_addr,
    output logic              conflict
);

    logic [DEPTH-1:0] hit;

    // Per-entry word match (byte offset bits ignored), then OR reduce.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (addr[i][ADDR_W-1:2] == probe_addr[ADDR_W-1:2]);
        end
        conflict = probe_en && (|hit);
    end

endmodule

// File: rtl/store_commit_buffer.sv
// FIFO of retired stores feeding the L1 data cache write port. The oldest
// store is presented combinationally from the head entry; loads that hit a
// buffered word are flagged for replay.
import store_commit_buffer_pkg::*;

module store_commit_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = SIZE_DCACHE_ADDR,
    parameter int unsigned DATA_W = SIZE_DATA,
    parameter int unsigned SZ_W   = LDST_TYPES_LOG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commitEn_i,
    input  logic [ADDR_W-1:0] commitAddr_i,
    input  logic [DATA_W-1:0] commitData_i,
    input  logic [SZ_W-1:0]   commitSize_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              wrEn_o,
    output logic [ADDR_W-1:0] wrAddr_o,
    output logic [DATA_W-1:0] wrData_o,
    output logic [SZ_W-1:0]   stSize_o,
    input  logic              wrHit_i,
    input  logic              ldEn_i,
    input  logic [ADDR_W-1:0] ldAddr_i,
    output logic              ldConflict_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    logic [DEPTH-1:0]  valid;
    logic              overflow;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [SZ_W-1:0]   size_q [DEPTH];
    logic              push;
    logic              pop;

    assign full_o     = (count == FULL_CNT);
    assign empty_o    = (count == '0);
    assign overflow_o = overflow;
    assign wrEn_o     = !empty_o;
    assign wrAddr_o   = addr_q[head];
    assign wrData_o   = data_q[head];
    assign stSize_o   = size_q[head];

    // full_o is taken before any pop, so a full buffer refuses a commit even
    // when the head drains in the same cycle.
    assign push = commitEn_i && !full_o;
    assign pop  = wrEn_o && wrHit_i;

    // Pointer, occupancy, valid-bit and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (commitEn_i && full_o) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry payload storage; only the valid bits need reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= commitAddr_i;
            data_q[tail] <= commitData_i;
            size_q[tail] <= commitSize_i;
        end
    end

    scb_addr_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_match (
        .valid      (valid),
        .addr       (addr_q),
        .probe_en   (ldEn_i),
        .probe_addr (ldAddr_i),
        .conflict   (ldConflict_o)
    );

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed table-driven bench for store_commit_buffer, plus a hand-written
// reset-while-pending sequence.
import store_commit_buffer_pkg::*;

module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        commitEn_i;
    logic [31:0] commitAddr_i;
    logic [31:0] commitData_i;
    logic [1:0]  commitSize_i;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
    logic        wrEn_o;
    logic [31:0] wrAddr_o;
    logic [31:0] wrData_o;
    logic [1:0]  stSize_o;
    logic        wrHit_i;
    logic        ldEn_i;
    logic [31:0] ldAddr_i;
    logic        ldConflict_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_commit_buffer #(
        .DEPTH  (8),
        .ADDR_W (32),
        .DATA_W (32),
        .SZ_W   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .commitEn_i   (commitEn_i),
        .commitAddr_i (commitAddr_i),
        .commitData_i (commitData_i),
        .commitSize_i (commitSize_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .overflow_o   (overflow_o),
        .wrEn_o       (wrEn_o),
        .wrAddr_o     (wrAddr_o),
        .wrData_o     (wrData_o),
        .stSize_o     (stSize_o),
        .wrHit_i      (wrHit_i),
        .ldEn_i       (ldEn_i),
        .ldAddr_i     (ldAddr_i),
        .ldConflict_o (ldConflict_o)
    );

    // One row = inputs held for one cycle + outputs expected before that cycle's edge.
    typedef struct {
        logic        ce;
        logic [31:0] ca;
        logic [31:0] cd;
        logic [1:0]  cs;
        logic        hit;
        logic        lde;
        logic [31:0] lda;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
        logic        e_wren;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_size;
        logic        e_conf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ce, input logic [31:0] ca, input logic [31:0] cd,
                       input logic [1:0] cs, input logic hit, input logic lde,
                       input logic [31:0] lda, input logic e_empty, input logic e_full,
                       input logic e_ovf, input logic e_wren, input logic [31:0] e_addr,
                       input logic [31:0] e_data, input logic [1:0] e_size,
                       input logic e_conf);
        vec_t v;
        v.ce = ce; v.ca = ca; v.cd = cd; v.cs = cs; v.hit = hit; v.lde = lde; v.lda = lda;
        v.e_empty = e_empty; v.e_full = e_full; v.e_ovf = e_ovf; v.e_wren = e_wren;
        v.e_addr = e_addr; v.e_data = e_data; v.e_size = e_size; v.e_conf = e_conf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] ca, input logic [31:0] cd,
                         input logic [1:0] cs, input logic hit, input logic lde,
                         input logic [31:0] lda);
        commitEn_i = ce; commitAddr_i = ca; commitData_i = cd; commitSize_i = cs;
        wrHit_i = hit; ldEn_i = lde; ldAddr_i = lda;
    endtask

    initial begin
        // Reset, idle, single store round trip
        add(0, 0, 0, 0, 1, 0, 0,                          1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 32'h1000, 32'hCAFEF00D, LDST_WORD, 1, 1, 32'h1000,
                                                          1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h1000,                   0, 0, 0, 1, 32'h1000, 32'hCAFEF00D, LDST_WORD, 1);
        add(0, 0, 0, 0, 1, 0, 0,                          1, 0, 0, 0, 0, 0, 0, 0);
        // Fill 8 with cache stalled; head held at 0x100
        add(1, 32'h100, 32'h5000_0000, LDST_WORD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++)
            add(1, 32'h100 + 4*i, 32'h5000_0000 + i, LDST_WORD, 0, 0, 0,
                0, 0, 0, 1, 32'h100, 32'h5000_0000, LDST_WORD, 0);
        // 9th commit while full is dropped
        add(1, 32'h200, 32'h6666_6666, LDST_WORD, 0, 0, 0, 0, 1, 0, 1, 32'h100, 32'h5000_0000, LDST_WORD, 0);
        add(0, 0, 0, 0, 0, 0, 0,                          0, 1, 1, 1, 32'h100, 32'h5000_0000, LDST_WORD, 0);
        // Full: commit with pop is refused, 8 -> 7
        add(1, 32'h300, 32'h7777_7777, LDST_WORD, 1, 0, 0, 0, 1, 1, 1, 32'h100, 32'h5000_0000, LDST_WORD, 0);
        add(0, 0, 0, 0, 0, 0, 0,                          0, 0, 1, 1, 32'h104, 32'h5000_0001, LDST_WORD, 0);
        for (int i = 1; i < 8; i++)
            add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h100 + 4*i, 32'h5000_0000 + i, LDST_WORD, 0);
        add(0, 0, 0, 0, 0, 0, 0,                          1, 0, 1, 0, 0, 0, 0, 0);
        // Count 3, commit with pop keeps count at 3
        add(1, 32'h400, 32'h4400_0000, LDST_HALF_WORD, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 32'h404, 32'h4400_0001, LDST_HALF_WORD, 0, 0, 0, 0, 0, 1, 1, 32'h400, 32'h4400_0000, LDST_HALF_WORD, 0);
        add(1, 32'h408, 32'h4400_0002, LDST_HALF_WORD, 0, 0, 0, 0, 0, 1, 1, 32'h400, 32'h4400_0000, LDST_HALF_WORD, 0);
        add(1, 32'h40C, 32'h4400_0003, LDST_HALF_WORD, 1, 0, 0, 0, 0, 1, 1, 32'h400, 32'h4400_0000, LDST_HALF_WORD, 0);
        add(0, 0, 0, 0, 0, 0, 0,                          0, 0, 1, 1, 32'h404, 32'h4400_0001, LDST_HALF_WORD, 0);
        for (int i = 1; i < 4; i++)
            add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h400 + 4*i, 32'h4400_0000 + i, LDST_HALF_WORD, 0);
        add(0, 0, 0, 0, 0, 0, 0,                          1, 0, 1, 0, 0, 0, 0, 0);
        // Byte store at 0x2003 and load probes
        add(1, 32'h2003, 32'h0000_00EE, LDST_BYTE, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 32'h2000,                   0, 0, 1, 1, 32'h2003, 32'hEE, LDST_BYTE, 1);
        add(0, 0, 0, 0, 0, 1, 32'h2004,                   0, 0, 1, 1, 32'h2003, 32'hEE, LDST_BYTE, 0);
        add(0, 0, 0, 0, 0, 0, 32'h2000,                   0, 0, 1, 1, 32'h2003, 32'hEE, LDST_BYTE, 0);
        add(0, 0, 0, 0, 1, 1, 32'h2003,                   0, 0, 1, 1, 32'h2003, 32'hEE, LDST_BYTE, 1);
        add(0, 0, 0, 0, 0, 1, 32'h2000,                   1, 0, 1, 0, 0, 0, 0, 0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].ce, vecs[k].ca, vecs[k].cd, vecs[k].cs,
                  vecs[k].hit, vecs[k].lde, vecs[k].lda);
            #1;
            chk("empty",    k, 32'(empty_o),      32'(vecs[k].e_empty));
            chk("full",     k, 32'(full_o),       32'(vecs[k].e_full));
            chk("overflow", k, 32'(overflow_o),   32'(vecs[k].e_ovf));
            chk("wr_en",    k, 32'(wrEn_o),       32'(vecs[k].e_wren));
            chk("conflict", k, 32'(ldConflict_o), 32'(vecs[k].e_conf));
            if (vecs[k].e_wren) begin
                chk("wr_addr", k, wrAddr_o,       vecs[k].e_addr);
                chk("wr_data", k, wrData_o,       vecs[k].e_data);
                chk("st_size", k, 32'(stSize_o),  32'(vecs[k].e_size));
            end
            @(negedge clk);
        end

        // Reset with 4 stores pending and the cache stalled
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h6000 + 4*i, 32'h9000_0000 + i, LDST_WORD, 0, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h6004);
        #1;
        chk("pre_rst_wr_en",    100, 32'(wrEn_o),       32'd1);
        chk("pre_rst_conflict", 100, 32'(ldConflict_o), 32'd1);
        chk("pre_rst_overflow", 100, 32'(overflow_o),   32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_empty",    101, 32'(empty_o),      32'd1);
        chk("rst_full",     101, 32'(full_o),       32'd0);
        chk("rst_wr_en",    101, 32'(wrEn_o),       32'd0);
        chk("rst_overflow", 101, 32'(overflow_o),   32'd0);
        chk("rst_conflict", 101, 32'(ldConflict_o), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_wr_en", 102, 32'(wrEn_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
